rv32_multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath select: ALU operand muxes, ALU operation, PC/IR/register-file write enables, and the memory request handshake. It sits beside the datapath, takes the opcode fields and ALU flags as inputs, and is the only block that writes architectural state enables.

---
 rtl/rv32_ctrl_pkg.sv | 81 ++++++++
 rtl/rv32_alu_op_decode.sv | 36 +++
 rtl/rv32_multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_rv32_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller and the datapath muxes it drives.
// Opcode classes, FSM states, ALU operation codes and every mux-select value live here.
package rv32_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_ILLEGAL = 4'd9
    } class_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] SRC_A_RS1    = 2'b00;
    localparam logic [1:0] SRC_A_PC     = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic MEM_SRC_PC     = 1'b0;
    localparam logic MEM_SRC_ALUOUT = 1'b1;
    localparam logic PC_SRC_ALU     = 1'b0;
    localparam logic PC_SRC_ALUOUT  = 1'b1;

    function automatic class_e opcode_class(input logic [6:0] op);
        case (op)
            OP_R:      return CLS_R;
            OP_I:      return CLS_I;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            OP_JAL:    return CLS_JAL;
            OP_JALR:   return CLS_JALR;
            OP_LUI:    return CLS_LUI;
            OP_AUIPC:  return CLS_AUIPC;
            default:   return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/rv32_alu_op_decode.sv
// Combinational ALU operation select from instruction class and funct fields.
// Classes that only need address/target arithmetic fall through to ADD.
module rv32_alu_op_decode
    import rv32_ctrl_pkg::*;
(
    input  logic [3:0] cls,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (cls == CLS_R || cls == CLS_I) begin
            case (funct3)
                // The immediate form has no SUB: instr[30] is part of the immediate there
                3'b000: alu_op = (cls == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001: alu_op = ALU_SLL;
                3'b010: alu_op = ALU_SLT;
                3'b011: alu_op = ALU_SLTU;
                3'b100: alu_op = ALU_XOR;
                3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                3'b110: alu_op = ALU_OR;
                3'b111: alu_op = ALU_AND;
            endcase
        end else if (cls == CLS_BRANCH) begin
            case (funct3[2:1])
                2'b00:   alu_op = ALU_SUB;
                2'b10:   alu_op = ALU_SLT;
                2'b11:   alu_op = ALU_SLTU;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state.
// Outputs are decoded from the current state (plus mem_ready and ALU flags) and forced low in reset.
module rv32_multicycle_ctrl
    import rv32_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_src,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       trap,
    output logic [2:0] state_o
);

    state_e     state_q;
    state_e     state_d;
    class_e     cls;
    logic [3:0] dec_alu_op;
    logic       br_taken;

    assign cls = opcode_class(opcode);

    // funct3[2] picks the flag (zero for EQ/NE, lt for the compares); funct3[0] inverts the sense
    assign br_taken = (funct3[2] ? alu_lt : alu_zero) ^ funct3[0];

    rv32_alu_op_decode u_alu_op_decode (
        .cls      (cls),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_op   (dec_alu_op)
    );

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_src   = MEM_SRC_PC;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_ALU;
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_ADD;
        rf_we     = 1'b0;
        wb_sel    = WB_ALUOUT;
        trap      = 1'b0;
        state_o   = state_q;

        case (state_q)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                state_d   = (cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_R: begin
                        alu_op  = dec_alu_op;
                        state_d = ST_WB;
                    end
                    CLS_I: begin
                        alu_src_b = SRC_B_IMM;
                        alu_op    = dec_alu_op;
                        state_d   = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b = SRC_B_IMM;
                        state_d   = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op = dec_alu_op;
                        if (funct3[2:1] == 2'b01) begin
                            state_d = ST_TRAP;
                        end else begin
                            pc_we   = br_taken;
                            pc_src  = br_taken;
                            state_d = ST_FETCH;
                        end
                    end
                    CLS_JAL: begin
                        pc_we   = 1'b1;
                        pc_src  = PC_SRC_ALUOUT;
                        rf_we   = 1'b1;
                        wb_sel  = WB_PC;
                        state_d = ST_FETCH;
                    end
                    // The RF write and PC update share this edge, so the link value is the pre-jump PC
                    CLS_JALR: begin
                        alu_src_b = SRC_B_IMM;
                        pc_we     = 1'b1;
                        rf_we     = 1'b1;
                        wb_sel    = WB_PC;
                        state_d   = ST_FETCH;
                    end
                    CLS_LUI: begin
                        alu_src_a = SRC_A_ZERO;
                        alu_src_b = SRC_B_IMM;
                        state_d   = ST_WB;
                    end
                    CLS_AUIPC: begin
                        alu_src_a = SRC_A_OLD_PC;
                        alu_src_b = SRC_B_IMM;
                        state_d   = ST_WB;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_src = MEM_SRC_ALUOUT;
                mem_we  = (cls == CLS_STORE);
                if (mem_ready) begin
                    state_d = (cls == CLS_STORE) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                wb_sel  = (cls == CLS_LOAD) ? WB_MEM : WB_ALUOUT;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset silences every enable in the same cycle so an aborted instruction leaves no trace
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_src   = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_src    = 1'b0;
            alu_src_a = 2'b00;
            alu_src_b = 2'b00;
            alu_op    = 4'd0;
            rf_we     = 1'b0;
            wb_sel    = 2'b00;
            trap      = 1'b0;
            state_o   = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed bench for rv32_multicycle_ctrl: each instruction is expanded into its expected
// per-cycle timeline from the ISA-level rules, and every cycle's outputs are compared against it.
module tb_rv32_multicycle_ctrl;

    localparam logic [6:0] L_R     = 7'h33;
    localparam logic [6:0] L_I     = 7'h13;
    localparam logic [6:0] L_LD    = 7'h03;
    localparam logic [6:0] L_ST    = 7'h23;
    localparam logic [6:0] L_BR    = 7'h63;
    localparam logic [6:0] L_JAL   = 7'h6F;
    localparam logic [6:0] L_JALR  = 7'h67;
    localparam logic [6:0] L_LUI   = 7'h37;
    localparam logic [6:0] L_AUIPC = 7'h17;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_src;
        logic       ir_we;
        logic       pc_we;
        logic       pc_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       trap;
        logic [2:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       alu_zero = 1'b0;
    logic       alu_lt = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_src, ir_we, pc_we, pc_src, rf_we, trap;
    logic [1:0] alu_src_a, alu_src_b, wb_sel;
    logic [3:0] alu_op;
    logic [2:0] state_o;
    exp_t       act;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc_cnt = 0;
    int         ir_cnt = 0;
    int         trap_cnt = 0;
    logic [3:0] exec_op = '0;
    logic [1:0] exec_pc = '0;
    logic [1:0] last_wb = '0;
    string      cur_name = "reset";

    always #5 clk = ~clk;

    rv32_multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .alu_zero  (alu_zero),
        .alu_lt    (alu_lt),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_src   (mem_src),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .trap      (trap),
        .state_o   (state_o)
    );

    assign act = {mem_req, mem_we, mem_src, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                  alu_op, rf_we, wb_sel, trap, state_o};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h required 0x%0h", name, $time, got, req);
        end
    endtask

    // ALU op from the ISA tables: funct3 nibble lookup, then the SUB/SRA refinements
    function automatic logic [3:0] model_op(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        logic [31:0] tbl;
        logic [3:0]  op;
        tbl = 32'h9865_4320;
        op  = 4'd0;
        if (opc == L_R || opc == L_I) begin
            op = tbl[f3*4 +: 4];
            if (f3 == 3'd5 && f7) op = 4'd7;
            if (opc == L_R && f3 == 3'd0 && f7) op = 4'd1;
        end else if (opc == L_BR) begin
            if (f3 < 3'd2) op = 4'd1;
            else if (f3 == 3'd4 || f3 == 3'd5) op = 4'd3;
            else if (f3 >= 3'd6) op = 4'd4;
        end
        return op;
    endfunction

    function automatic bit model_taken(input logic [2:0] f3, input logic z, input logic l);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return l;
            3'd7: return !l;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit legal(input logic [6:0] opc);
        return opc inside {L_R, L_I, L_LD, L_ST, L_BR, L_JAL, L_JALR, L_LUI, L_AUIPC};
    endfunction

    // One clock cycle: drive inputs after the edge, compare at the falling edge
    task automatic cyc(input logic r, input logic rdy, input logic [6:0] opc, input logic [2:0] f3,
                       input logic f7, input logic z, input logic l, input exp_t e);
        @(posedge clk);
        #1;
        rst = r; mem_ready = rdy; opcode = opc; funct3 = f3; funct7_5 = f7;
        alu_zero = z; alu_lt = l;
        @(negedge clk);
        check({cur_name, "_cycle"}, 32'(act), 32'(e));
        if (!rst) cyc_cnt++;
        if (ir_we) ir_cnt++;
        if (trap) trap_cnt++;
        if (state_o == 3'd2) begin
            exec_op = alu_op;
            exec_pc = {pc_we, pc_src};
        end
        if (rf_we) last_wb = wb_sel;
    endtask

    task automatic run_instr(input string nm, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input logic z, input logic l, input int fw, input int mw,
                             input int ntrap, input bit abort);
        exp_t e;
        bit   trap_next;
        bit   do_wb;
        cur_name = nm;
        for (int i = 0; i <= fw; i++) begin
            e = '0; e.mem_req = 1'b1; e.a = 2'b01; e.b = 2'b10;
            if (i == fw) begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
            cyc(1'b0, (i == fw), 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, e);
        end
        e = '0; e.a = 2'b10; e.b = 2'b01; e.st = 3'd1;
        cyc(1'b0, 1'b1, opc, f3, f7, 1'b0, 1'b0, e);
        if (abort) begin
            cyc(1'b1, 1'b1, opc, f3, f7, z, l, '0);
            cyc(1'b1, 1'b1, opc, f3, f7, z, l, '0);
            return;
        end
        trap_next = !legal(opc);
        if (!trap_next) begin
            e = '0; e.st = 3'd2;
            do_wb = opc inside {L_R, L_I, L_LUI, L_AUIPC, L_LD};
            case (opc)
                L_R:   e.op = model_op(opc, f3, f7);
                L_I:   begin e.b = 2'b01; e.op = model_op(opc, f3, f7); end
                L_LD, L_ST: e.b = 2'b01;
                L_BR: begin
                    e.op = model_op(opc, f3, f7);
                    if (f3 == 3'd2 || f3 == 3'd3) trap_next = 1'b1;
                    else if (model_taken(f3, z, l)) begin e.pc_we = 1'b1; e.pc_src = 1'b1; end
                end
                L_JAL:  begin e.pc_we = 1'b1; e.pc_src = 1'b1; e.rf_we = 1'b1; e.wb_sel = 2'b10; end
                L_JALR: begin e.b = 2'b01; e.pc_we = 1'b1; e.rf_we = 1'b1; e.wb_sel = 2'b10; end
                L_LUI:  begin e.a = 2'b11; e.b = 2'b01; end
                L_AUIPC: begin e.a = 2'b10; e.b = 2'b01; end
                default: ;
            endcase
            cyc(1'b0, 1'b1, opc, f3, f7, z, l, e);
            if (opc == L_LD || opc == L_ST) begin
                for (int i = 0; i <= mw; i++) begin
                    e = '0; e.mem_req = 1'b1; e.mem_src = 1'b1; e.mem_we = (opc == L_ST); e.st = 3'd3;
                    cyc(1'b0, (i == mw), opc, f3, f7, 1'b0, 1'b0, e);
                end
            end
            if (do_wb) begin
                e = '0; e.rf_we = 1'b1; e.wb_sel = (opc == L_LD) ? 2'b01 : 2'b00; e.st = 3'd4;
                cyc(1'b0, 1'b1, opc, f3, f7, 1'b0, 1'b0, e);
            end
        end
        if (trap_next) begin
            for (int i = 0; i < ntrap; i++) begin
                e = '0; e.trap = 1'b1; e.st = 3'd5;
                cyc(1'b0, 1'b1, opc, f3, f7, 1'b1, 1'b1, e);
            end
            cyc(1'b1, 1'b1, opc, f3, f7, 1'b0, 1'b0, '0);
        end
    endtask

    initial begin
        int b_cyc;
        int b_ir;
        int b_trap;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, L_R, 3'd0, 1'b0, 1'b0, 1'b0, '0);

        b_cyc = cyc_cnt;
        run_instr("add", L_R, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("add_cycles", cyc_cnt - b_cyc, 4);
        check("add_op", exec_op, 4'd0);

        b_cyc = cyc_cnt;
        run_instr("rst_abort", L_R, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        check("abort_cycles", cyc_cnt - b_cyc, 2);

        run_instr("sub", L_R, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("sub_op", exec_op, 4'd1);
        run_instr("srai", L_I, 3'd5, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("srai_op", exec_op, 4'd7);
        run_instr("addi_f7", L_I, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("addi_f7_op", exec_op, 4'd0);
        run_instr("sltu", L_R, 3'd3, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b0);
        run_instr("xori", L_I, 3'd4, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_instr("srl", L_R, 3'd5, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        b_cyc = cyc_cnt; b_ir = ir_cnt;
        run_instr("lw", L_LD, 3'd2, 1'b0, 1'b0, 1'b0, 3, 2, 0, 1'b0);
        check("lw_cycles", cyc_cnt - b_cyc, 10);
        check("lw_ir_pulses", ir_cnt - b_ir, 1);
        check("lw_wb_sel", last_wb, 2'b01);

        b_cyc = cyc_cnt;
        run_instr("sw", L_ST, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("sw_cycles", cyc_cnt - b_cyc, 4);
        run_instr("sw_wait", L_ST, 3'd2, 1'b0, 1'b0, 1'b0, 0, 1, 0, 1'b0);

        b_cyc = cyc_cnt;
        run_instr("bne_taken", L_BR, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("bne_taken_pc", exec_pc, 2'b11);
        check("bne_cycles", cyc_cnt - b_cyc, 3);
        run_instr("bne_not", L_BR, 3'd1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        check("bne_not_pc", exec_pc, 2'b00);
        run_instr("bgeu_lt", L_BR, 3'd7, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0);
        check("bgeu_lt_pc", exec_pc, 2'b00);
        run_instr("blt_lt", L_BR, 3'd4, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0);
        run_instr("beq_z", L_BR, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        run_instr("bge_nlt", L_BR, 3'd5, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);

        b_cyc = cyc_cnt;
        run_instr("jal", L_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("jal_cycles", cyc_cnt - b_cyc, 3);
        run_instr("jalr", L_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_instr("lui", L_LUI, 3'd3, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_instr("auipc", L_AUIPC, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_instr("br_f3_010", L_BR, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0, 2, 1'b0);

        b_trap = trap_cnt;
        run_instr("illegal_7f", 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 10, 1'b0);
        check("trap_cycles", trap_cnt - b_trap, 10);

        b_cyc = cyc_cnt;
        run_instr("addi_after", L_I, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("addi_after_cycles", cyc_cnt - b_cyc, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
